if_prefetch_queue: RTL and testbench

IF_PREFETCH_QUEUE -- requirements
Module: if_prefetch_queue

---
 rtl/if_prefetch_queue_pkg.sv | 22 ++
 rtl/fetch_slot_ring.sv | 74 +++++++
 rtl/if_prefetch_queue.sv | 99 +++++++++
 tb/tb_if_prefetch_queue.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_prefetch_queue_pkg.sv
// Shared slot payload and sizing helpers for the instruction prefetch queue.
// Slot fields are sized for the widest supported PC/instruction (64 bits).
package Fetch_PKG;

  localparam int unsigned SLOT_PC_W  = 64;
  localparam int unsigned SLOT_INS_W = 64;

  typedef struct packed {
    logic [SLOT_PC_W-1:0]  pc;
    logic [SLOT_INS_W-1:0] instr;
    logic                  filled;
  } fetch_slot_t;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_slot_ring.sv
// Circular slot store for the prefetch queue: allocation, fill and head pointers,
// with occupancy and unfilled-slot counts derived from pointer differences.
module fetch_slot_ring
  import Fetch_PKG::*;
#(
  parameter int unsigned  PC_W  = 32,
  parameter int unsigned  INS_W = 32,
  parameter int unsigned  DEPTH = 4,
  localparam int unsigned CNT_W = cnt_width(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             alloc,
  input  logic [PC_W-1:0]  alloc_pc,
  input  logic             fill,
  input  logic [INS_W-1:0] fill_instr,
  input  logic             pop,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] pending,
  output logic             head_valid,
  output logic [PC_W-1:0]  head_pc,
  output logic [INS_W-1:0] head_instr
);

  localparam int unsigned PTR_W = ptr_width(DEPTH);

  fetch_slot_t      slots_q [DEPTH];
  logic [CNT_W-1:0] alloc_ptr_q;
  logic [CNT_W-1:0] fill_ptr_q;
  logic [CNT_W-1:0] head_ptr_q;
  logic [PTR_W-1:0] alloc_idx;
  logic [PTR_W-1:0] fill_idx;
  logic [PTR_W-1:0] head_idx;

  // Pointers carry one wrap bit above the index so full and empty differ.
  assign alloc_idx = alloc_ptr_q[PTR_W-1:0];
  assign fill_idx  = fill_ptr_q[PTR_W-1:0];
  assign head_idx  = head_ptr_q[PTR_W-1:0];

  assign count      = alloc_ptr_q - head_ptr_q;
  assign pending    = alloc_ptr_q - fill_ptr_q;
  assign head_valid = (count != '0) && slots_q[head_idx].filled;
  assign head_pc    = slots_q[head_idx].pc[PC_W-1:0];
  assign head_instr = slots_q[head_idx].instr[INS_W-1:0];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      head_ptr_q  <= '0;
      for (int i = 0; i < DEPTH; i++) slots_q[i] <= '0;
    end else if (flush) begin
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      head_ptr_q  <= '0;
    end else begin
      if (alloc) begin
        slots_q[alloc_idx].pc     <= SLOT_PC_W'(alloc_pc);
        slots_q[alloc_idx].filled <= 1'b0;
        alloc_ptr_q               <= alloc_ptr_q + CNT_W'(1);
      end
      if (fill) begin
        slots_q[fill_idx].instr  <= SLOT_INS_W'(fill_instr);
        slots_q[fill_idx].filled <= 1'b1;
        fill_ptr_q               <= fill_ptr_q + CNT_W'(1);
      end
      if (pop) begin
        head_ptr_q <= head_ptr_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue: issues sequential fetches, buffers in-order responses
// for decode, and drops responses still in flight across a redirect.
module if_prefetch_queue
  import Fetch_PKG::*;
#(
  parameter int unsigned     PC_W     = 32,
  parameter int unsigned     INS_W    = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  localparam int unsigned    CNT_W    = cnt_width(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             redirect_valid,
  input  logic [PC_W-1:0]  redirect_pc,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [INS_W-1:0] imem_rdata,
  output logic             if_valid,
  output logic [PC_W-1:0]  if_pc,
  output logic [INS_W-1:0] if_instr,
  input  logic             if_ready,
  output logic [CNT_W-1:0] fifo_count
);

  logic [PC_W-1:0]  pc_q;
  logic [CNT_W-1:0] drop_q;
  logic [CNT_W-1:0] drop_d;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] pending;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W:0]   budget;
  logic             req_ok;
  logic             grant;
  logic             rsp_drop;
  logic             rsp_fill;
  logic             head_valid;
  logic             pop;

  // Slots in use plus responses still owed to stale fetches bound new requests.
  assign budget      = (CNT_W+1)'(count) + (CNT_W+1)'(drop_q);
  assign req_ok      = !redirect_valid && (budget < (CNT_W+1)'(DEPTH));
  assign imem_req    = req_ok && reset;
  assign imem_addr   = pc_q;
  assign grant       = req_ok && imem_gnt;
  assign outstanding = drop_q + pending;
  assign rsp_drop    = imem_rvalid && (drop_q != '0);
  assign rsp_fill    = imem_rvalid && (drop_q == '0) && (pending != '0) && !redirect_valid;
  assign if_valid    = head_valid && !redirect_valid;
  assign pop         = if_valid && if_ready;
  assign fifo_count  = count;

  // A redirect turns every unanswered fetch into a drop, less this cycle's response.
  always_comb begin
    drop_d = drop_q;
    if (redirect_valid) begin
      drop_d = outstanding - CNT_W'(imem_rvalid && (outstanding != '0));
    end else if (rsp_drop) begin
      drop_d = drop_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q   <= RESET_PC;
      drop_q <= '0;
    end else begin
      drop_q <= drop_d;
      if (redirect_valid) begin
        pc_q <= redirect_pc;
      end else if (grant) begin
        pc_q <= pc_q + PC_W'(4);
      end
    end
  end

  fetch_slot_ring #(
    .PC_W  (PC_W),
    .INS_W (INS_W),
    .DEPTH (DEPTH)
  ) u_ring (
    .clock      (clock),
    .reset      (reset),
    .flush      (redirect_valid),
    .alloc      (grant),
    .alloc_pc   (pc_q),
    .fill       (rsp_fill),
    .fill_instr (imem_rdata),
    .pop        (pop),
    .count      (count),
    .pending    (pending),
    .head_valid (head_valid),
    .head_pc    (if_pc),
    .head_instr (if_instr)
  );

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Scoreboard bench for if_prefetch_queue: a queue-level model of the delivered
// instruction stream, an in-order memory with random latency, and a PC_W=8 instance.
module tb_if_prefetch_queue;

  localparam int unsigned DEPTH = 4;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    bit          filled;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          rdy;
  } mreq_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready;
  logic [2:0]  fifo_count;

  logic        s_req;
  logic [7:0]  s_addr;
  logic        s_valid;
  logic [7:0]  s_pc;
  logic [31:0] s_instr;
  logic [2:0]  s_count;

  always #5 clock = ~clock;

  if_prefetch_queue #(.PC_W(32), .INS_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clock(clock), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .if_ready(if_ready),
    .fifo_count(fifo_count)
  );

  if_prefetch_queue #(.PC_W(8), .INS_W(32), .DEPTH(DEPTH), .RESET_PC(8'hFC)) dut8 (
    .clock(clock), .reset(reset), .redirect_valid(1'b0), .redirect_pc(8'h00),
    .imem_req(s_req), .imem_addr(s_addr), .imem_gnt(1'b1),
    .imem_rvalid(1'b0), .imem_rdata(32'h0),
    .if_valid(s_valid), .if_pc(s_pc), .if_instr(s_instr), .if_ready(1'b0),
    .fifo_count(s_count)
  );

  exp_t        sb[$];
  mreq_t       memq[$];
  logic [31:0] gaddr[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          epoch = 0;
  int          grants = 0;
  int          pops = 0;
  logic [31:0] model_pc = 32'h0;
  bit          pend_fill = 1'b0;
  int          gnt_mode = 1, rsp_mode = 1, rdy_mode = 1, redir_pct = 0;
  bit          force_redir = 1'b0;
  logic [31:0] force_pc = 32'h0;
  bit          watch_first = 1'b0;
  logic [31:0] first_pc = 32'hFFFF_FFFF;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic int stale_cnt();
    int n = 0;
    foreach (memq[i]) if (memq[i].epoch != epoch) n++;
    return n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock window: inputs at negedge, combinational outputs checked 1ns later.
  task automatic step();
    bit grant, rsp, spurious, do_redir, exp_req, done;
    exp_t e;
    mreq_t m;
    @(negedge clock);
    cyc++;
    reset = 1'b1;
    if (pend_fill) begin
      done = 1'b0;
      foreach (sb[i]) if (!sb[i].filled && !done) begin
        e = sb[i]; e.filled = 1'b1; sb[i] = e; done = 1'b1;
      end
      pend_fill = 1'b0;
    end
    imem_gnt = (gnt_mode == 1) ? 1'b1 : (gnt_mode == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
    if_ready = (rdy_mode == 1) ? 1'b1 : (rdy_mode == 2) ? 1'b0 : ($urandom_range(0, 2) != 0);
    do_redir = force_redir || (redir_pct != 0 && $urandom_range(0, 99) < redir_pct);
    redirect_valid = do_redir;
    redirect_pc = force_redir ? force_pc : ($urandom() & 32'hFFFF_FFFC);
    force_redir = 1'b0;
    rsp = 1'b0;
    if (memq.size() > 0 && memq[0].rdy <= cyc)
      rsp = (rsp_mode == 1) || (rsp_mode == 0 && $urandom_range(0, 1) == 1);
    spurious = (memq.size() == 0) && (rsp_mode == 0) && ($urandom_range(0, 9) == 0);
    imem_rvalid = rsp || spurious;
    imem_rdata = rsp ? mem_fn(memq[0].addr) : $urandom();
    #1;
    exp_req = !do_redir && ((sb.size() + stale_cnt()) < DEPTH);
    check("imem_req", imem_req, exp_req);
    check("fifo_count", fifo_count, sb.size());
    if (!do_redir) check("imem_addr", imem_addr, model_pc);
    grant = exp_req && imem_gnt;
    if (rsp) begin
      m = memq.pop_front();
      if (m.epoch == epoch && !do_redir) pend_fill = 1'b1;
    end
    if (do_redir) begin
      sb.delete();
      epoch++;
      model_pc = redirect_pc;
    end else if (grant) begin
      memq.push_back('{addr: model_pc, epoch: epoch, rdy: cyc + 1});
      sb.push_back('{pc: model_pc, instr: mem_fn(model_pc), filled: 1'b0});
      gaddr.push_back(model_pc);
      grants++;
      model_pc = model_pc + 32'd4;
    end
  endtask

  // Reset is asserted mid-window; the memory model forgets everything in flight.
  task automatic do_reset();
    @(negedge clock);
    cyc++;
    reset = 1'b0;
    redirect_valid = 1'b0;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    if_ready = 1'b0;
    sb.delete();
    memq.delete();
    pend_fill = 1'b0;
    model_pc = 32'h0;
    #1;
    check("rst_if_valid", if_valid, 1'b0);
    check("rst_imem_req", imem_req, 1'b0);
    check("rst_fifo_count", fifo_count, 3'd0);
    check("rst_imem_addr", imem_addr, 32'h0);
  endtask

  // Monitor: compares every instruction decode consumes against the scoreboard head.
  initial begin : monitor
    bit exp_v;
    forever begin
      @(negedge clock);
      #2;
      exp_v = reset && !redirect_valid && (sb.size() > 0) && sb[0].filled;
      check("if_valid", if_valid, exp_v);
      if (if_valid && if_ready && exp_v) begin
        check("if_pc", if_pc, sb[0].pc);
        check("if_instr", if_instr, sb[0].instr);
        if (watch_first) begin
          first_pc = if_pc;
          watch_first = 1'b0;
        end
        pops++;
        sb.delete(0);
      end
    end
  end

  initial begin : driver
    int g0;
    int p0;
    logic [31:0] a0;
    logic [31:0] got;
    reset = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = 32'h0;
    if_ready = 1'b0;

    do_reset();
    check("pc8_reset_addr", s_addr, 8'hFC);
    check("pc8_reset_req", s_req, 1'b0);

    // Streaming: always granted, single-cycle memory, decode always ready.
    gnt_mode = 1; rsp_mode = 1; rdy_mode = 1; redir_pct = 0;
    step();
    check("pc8_addr_first", s_addr, 8'hFC);
    check("pc8_req", s_req, 1'b1);
    step();
    check("pc8_addr_wrap", s_addr, 8'h00);
    check("pc8_valid", s_valid, 1'b0);
    p0 = pops;
    repeat (30) step();
    check("stream_throughput", ((pops - p0) >= 27), 1'b1);

    // Decode stalled: queue fills to DEPTH then requests stop at 0x10.
    do_reset();
    rdy_mode = 2;
    g0 = grants;
    repeat (10) step();
    check("stall_grants", grants - g0, DEPTH);
    check("stall_fifo_count", fifo_count, 3'd4);
    check("stall_req", imem_req, 1'b0);
    check("stall_addr", imem_addr, 32'h10);
    rdy_mode = 1;
    repeat (4) step();
    got = (gaddr.size() > g0 + 4) ? gaddr[g0 + 4] : 32'hFFFF_FFFF;
    check("resume_addr", got, 32'h10);

    // Redirect to 0x100 with two fetches outstanding.
    do_reset();
    rsp_mode = 2;
    repeat (2) step();
    force_redir = 1'b1;
    force_pc = 32'h100;
    step();
    rsp_mode = 1;
    watch_first = 1'b1;
    repeat (12) step();
    check("redirect_first_pc", first_pc, 32'h100);

    // Grant withheld for three cycles: address holds, PC does not move.
    a0 = model_pc;
    g0 = grants;
    gnt_mode = 2;
    repeat (3) begin
      step();
      check("nognt_addr", imem_addr, a0);
    end
    check("nognt_grants", grants - g0, 0);
    gnt_mode = 1;
    repeat (2) step();
    got = (gaddr.size() > g0) ? gaddr[g0] : 32'hFFFF_FFFF;
    check("nognt_next_addr", got, a0);

    // Random traffic with redirects, spurious responses and a mid-stream reset.
    gnt_mode = 0; rsp_mode = 0; rdy_mode = 0; redir_pct = 4;
    repeat (800) step();
    do_reset();
    g0 = grants;
    repeat (800) step();
    got = (gaddr.size() > g0) ? gaddr[g0] : 32'hFFFF_FFFF;
    check("post_reset_first_addr", got, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
